// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS main controller and its datapath.
// The controller owns the master modport; the datapath (or a bench) uses the slave side.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       BranchNE;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op,
               state
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op,
               state
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore main controller for the multi-cycle MIPS datapath: fetch/decode/execute/memory/write-back
// sequencing with memory-ready stalls and a sticky HALT on unsupported opcodes.
module multicycle_control #(
    parameter logic [5:0] OP_R    = 6'b000000,
    parameter logic [5:0] OP_LW   = 6'b100011,
    parameter logic [5:0] OP_SW   = 6'b101011,
    parameter logic [5:0] OP_BEQ  = 6'b000100,
    parameter logic [5:0] OP_BNE  = 6'b000101,
    parameter logic [5:0] OP_ADDI = 6'b001000,
    parameter logic [5:0] OP_J    = 6'b000010
) (
    input logic                  clk,
    input logic                  reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11,
        StHalt   = 4'd15
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
        logic       fetch_gate;  // IRWrite/PCWrite follow mem_ready
        logic       memwr_gate;  // instr_done follows mem_ready
    } ctrl_t;

    state_e state_q, state_d;
    logic   bne_q, bne_d;
    ctrl_t  ctrl_q, ctrl_d;

    function automatic ctrl_t decode_ctrl(state_e st, logic bne);
        ctrl_t c;
        c = '0;
        case (st)
            StFetch:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.fetch_gate = 1'b1; end
            StDecode: c.alu_src_b = 2'b11;
            StMemAdr: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            StMemRd:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
            StMemWb:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
            StMemWr:  begin c.mem_write = 1'b1; c.iord = 1'b1; c.memwr_gate = 1'b1; end
            StExec:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            StAluWb:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
            StBranch: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_source     = 2'b01;
                c.pc_write_cond = 1'b1;
                c.branch_ne     = bne;
                c.instr_done    = 1'b1;
            end
            StJump:   begin c.pc_source = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1; end
            StAddiEx: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            StAddiWb: begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
            StHalt:   c.illegal_op = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        bne_d   = bne_q;
        case (state_q)
            StFetch:  if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                bne_d = (bus.opcode == OP_BNE);
                case (bus.opcode)
                    OP_LW, OP_SW:   state_d = StMemAdr;
                    OP_R:           state_d = StExec;
                    OP_BEQ, OP_BNE: state_d = StBranch;
                    OP_J:           state_d = StJump;
                    OP_ADDI:        state_d = StAddiEx;
                    default:        state_d = StHalt;
                endcase
            end
            StMemAdr: state_d = (bus.opcode == OP_LW) ? StMemRd : StMemWr;
            StMemRd:  if (bus.mem_ready) state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  if (bus.mem_ready) state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StJump:   state_d = StFetch;
            StAddiEx: state_d = StAddiWb;
            StAddiWb: state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StHalt;
        endcase
        ctrl_d = decode_ctrl(state_d, bne_d);
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            bne_q   <= 1'b0;
            ctrl_q  <= decode_ctrl(StFetch, 1'b0);
        end else begin
            state_q <= state_d;
            bne_q   <= bne_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.PCWrite     = ctrl_q.pc_write | (ctrl_q.fetch_gate & bus.mem_ready);
    assign bus.PCWriteCond = ctrl_q.pc_write_cond;
    assign bus.BranchNE    = ctrl_q.branch_ne;
    assign bus.IorD        = ctrl_q.iord;
    assign bus.MemRead     = ctrl_q.mem_read;
    assign bus.MemWrite    = ctrl_q.mem_write;
    assign bus.IRWrite     = ctrl_q.fetch_gate & bus.mem_ready;
    assign bus.MemtoReg    = ctrl_q.mem_to_reg;
    assign bus.RegDst      = ctrl_q.reg_dst;
    assign bus.RegWrite    = ctrl_q.reg_write;
    assign bus.ALUSrcA     = ctrl_q.alu_src_a;
    assign bus.ALUSrcB     = ctrl_q.alu_src_b;
    assign bus.ALUOp       = ctrl_q.alu_op;
    assign bus.PCSource    = ctrl_q.pc_source;
    assign bus.instr_done  = ctrl_q.instr_done | (ctrl_q.memwr_gate & bus.mem_ready);
    assign bus.illegal_op  = ctrl_q.illegal_op;
    assign bus.state       = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-style main controller for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back for R-type, lw, sw, beq, bne, addi and j, one instruction at a time. It replaces the single-cycle combinational decoder. It stalls on a memory-ready handshake and traps on unsupported opcodes.

Parameters:
OP_R, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word
OP_SW, 6'b101011, store word
OP_BEQ, 6'b000100, branch equal
OP_BNE, 6'b000101, branch not equal
OP_ADDI, 6'b001000, add immediate
OP_J, 6'b000010, jump

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high
opcode  in  6  IR[31:26]; stable from the cycle after FETCH completes
mem_ready  in  1  memory completes the current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  conditional PC load (branch)
BranchNE  out  1  1: condition is !Zero; 0: condition is Zero
IorD  out  1  0: address=PC; 1: address=ALUOut
MemRead  out  1  memory read
MemWrite  out  1  memory write
IRWrite  out  1  load instruction register
MemtoReg  out  1  write-back source is MDR
RegDst  out  1  destination is rd (1) / rt (0)
RegWrite  out  1  register file write
ALUSrcA  out  1  0: PC; 1: register A
ALUSrcB  out  2  00: B, 01: const 4, 10: sign-ext imm, 11: sign-ext imm<<2
ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
instr_done  out  1  one-cycle pulse in the last cycle of each instruction
illegal_op  out  1  high while in HALT
state  out  4  current state, for debug

Behaviour:
- State register is 4 bits. Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=15.
- Reset: on any edge with reset=1, state<=FETCH and bne_flag<=0, regardless of the current state, including a mid-stall MEMWR or MEMRD.
- Every output not listed for a state is 0. No output is ever driven to x. After reset, outputs equal the FETCH values.
- FETCH: MemRead=1, ALUSrcB=01, IRWrite=PCWrite=mem_ready. Holds while mem_ready=0. Goes to DECODE when mem_ready=1.
- DECODE: ALUSrcB=11. Latches bne_flag=(opcode==OP_BNE). Next state by opcode: lw/sw go to MEMADR, R goes to EXEC, beq/bne go to BRANCH, j goes to JUMP, addi goes to ADDIEX, any other opcode goes to HALT.
- MEMADR: ALUSrcA=1, ALUSrcB=10. Goes to MEMRD if lw, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, instr_done=1. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1, instr_done=mem_ready. Holds until mem_ready=1, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUOp=10. Goes to ALUWB. ALUWB: RegDst=1, RegWrite=1, instr_done=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSource=01, PCWriteCond=1, BranchNE=bne_flag, instr_done=1. Goes to FETCH.
- JUMP: PCSource=10, PCWrite=1, instr_done=1. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Goes to ADDIWB. ADDIWB: RegWrite=1, instr_done=1. Goes to FETCH.
- HALT: illegal_op=1, all other outputs 0. Sticky until reset.
- Latency with zero memory stalls: R=4, lw=5, sw=4, beq/bne=3, j=3, addi=4 cycles. Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready is ignored in all states other than FETCH, MEMRD and MEMWR.
- Unused state codes 12-14 go to HALT on the next edge.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 and opcode=000000 -> state sequence 0,1,6,7,0. ALUWB shows RegDst=1, RegWrite=1, instr_done=1. Exactly one instr_done pulse.
- lw (100011) with mem_ready low for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0. MemRead=IorD=1 held throughout the stall. MEMWB shows MemtoReg=1, RegWrite=1.
- sw (101011), then reset asserted during the second MEMWR stall cycle -> next state is 0. MemWrite=0 from that edge onward. No instr_done pulse.
- beq (000100), then bne (000101) -> BRANCH shows PCWriteCond=1, PCSource=01, ALUOp=01, with BranchNE=0 for beq and 1 for bne. Each instruction takes 3 cycles.
- j (000010), then addi (001000) -> JUMP shows PCWrite=1, PCSource=10. addi follows states 0,1,10,11 with ALUSrcB=10 in state 10 and RegWrite=1, RegDst=0 in state 11.
- FETCH with mem_ready=0 for 2 cycles -> IRWrite=PCWrite=0 during the stall and 1 in the completing cycle. Then opcode=111111 -> HALT, illegal_op=1 stays set for 10 cycles, and clears only after reset.
